// File: rtl/if_id_queue.sv
// if_id_queue: elastic in-order IF/ID buffer of {pc, inst, side} with
// valid/ready backpressure on both sides, branch flush and empty bubble.
module if_id_queue #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int SIDEW = 1,
  parameter int DEPTH = 2,
  parameter logic [ILEN-1:0] BUBBLE_INST = '0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [ILEN-1:0]  i_inst,
  input  logic [SIDEW-1:0] i_side,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic [ILEN-1:0]  o_inst,
  output logic [SIDEW-1:0] o_side,
  output logic [CW-1:0]    o_count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [ILEN-1:0]  inst_mem [DEPTH];
  logic [SIDEW-1:0] side_mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  // Handshake flags depend only on the registered count, never on i_valid/i_ready.
  always_comb begin
    o_ready  = count_q < CW'(DEPTH);
    o_valid  = count_q != '0;
    push     = i_valid & o_ready;
    pop      = o_valid & i_ready;
    rd_ptr_d = i_flush ? '0 : pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    wr_ptr_d = i_flush ? '0 : push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    count_d  = i_flush ? '0 : count_q + CW'(push) - CW'(pop);
    o_count  = count_q;
    o_pc     = o_valid ? pc_mem[rd_ptr_q] : '0;
    o_inst   = o_valid ? inst_mem[rd_ptr_q] : BUBBLE_INST;
    o_side   = o_valid ? side_mem[rd_ptr_q] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  always_ff @(posedge clk)
    if (push && !i_flush) begin
      pc_mem[wr_ptr_q]   <= i_pc;
      inst_mem[wr_ptr_q] <= i_inst;
      side_mem[wr_ptr_q] <= i_side;
    end
endmodule
